// File: rtl/shiftreg_frame_serializer.sv
// -----------------------------------------------------------------------------
// shiftreg_frame_serializer
//
// Captures a static word and a dynamic word on START and serialises them
// (static only, dynamic only, or static then dynamic) onto a single bit stream
// under a valid/ready handshake. The bit order of each word is chosen per
// frame with LSB_FIRST. DONE pulses once the last bit of a frame has been
// accepted; ERR pulses when a frame is requested with the illegal mode 2'b11.
// Sits between the register-config interface and the serial line driver.
//
// Optional feature macro: SHIFTREG_PARITY_EN
//   defined     -> one extra even-parity bit (XOR of all data bits of the
//                  frame) is sent after the last data bit, same handshake.
//   not defined -> no parity state, DONE follows the last data bit.
//
// Parameters
//   STAT_W    static word width (>= 2)
//   DYN_W     dynamic word width (>= 2)
//   CNT_W     bit-counter width, 2**CNT_W >= max(STAT_W, DYN_W)
//   STAT_DEF  reset value of static latch / shift register
//   DYN_DEF   reset value of dynamic latch / shift register
//
// Ports
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous reset, active low
//   START      in   frame request, sampled only while idle
//   MODE       in   00 static, 01 dynamic, 10 static then dynamic, 11 illegal
//   LSB_FIRST  in   1: each word LSB first, 0: MSB first (sampled with START)
//   STATREG    in   static word source
//   DYNREG     in   dynamic word source
//   SREADY     in   downstream accepts the current bit
//   SDATA      out  serial bit, valid when SVALID=1
//   SVALID     out  serial bit valid
//   BUSY       out  frame in progress
//   DONE       out  one-cycle pulse after the last bit of a frame is accepted
//   ERR        out  one-cycle pulse on START with MODE=11
//   STATLATCH  out  static word captured at the last accepted START
//   DYNLATCH   out  dynamic word captured at the last accepted START
// -----------------------------------------------------------------------------
module shiftreg_frame_serializer #(
  parameter int                STAT_W   = 88,
  parameter int                DYN_W    = 16,
  parameter int                CNT_W    = 7,
  parameter logic [STAT_W-1:0] STAT_DEF = 88'h123456789ABCDEF1234567,
  parameter logic [DYN_W-1:0]  DYN_DEF  = 16'hABCD
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic              LSB_FIRST,
  input  logic [STAT_W-1:0] STATREG,
  input  logic [DYN_W-1:0]  DYNREG,
  input  logic              SREADY,
  output logic              SDATA,
  output logic              SVALID,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [STAT_W-1:0] STATLATCH,
  output logic [DYN_W-1:0]  DYNLATCH
);

  localparam logic [1:0] MODE_STAT = 2'b00;
  localparam logic [1:0] MODE_DYN  = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  // Counter value of the final bit of each word.
  localparam logic [CNT_W-1:0] STAT_LAST = CNT_W'(STAT_W - 1);
  localparam logic [CNT_W-1:0] DYN_LAST  = CNT_W'(DYN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SH_STAT = 2'd1,
    ST_SH_DYN  = 2'd2
`ifdef SHIFTREG_PARITY_EN
    ,
    ST_SH_PAR  = 2'd3
`endif
  } state_t;

  state_t              state;
  logic [STAT_W-1:0]   stat_sh;
  logic [DYN_W-1:0]    dyn_sh;
  logic [CNT_W-1:0]    cnt;
  logic                lsb_q;
  logic [1:0]          mode_q;
`ifdef SHIFTREG_PARITY_EN
  logic                par_acc;
`endif

  // Handshake and next-bit helpers.
  // NOTE: continuous assigns (or always_comb with full defaults) keep this
  // logic purely combinational, so no latches can be inferred.
  logic              xfer;
  logic              data_last;
  logic [STAT_W-1:0] stat_shifted;
  logic [DYN_W-1:0]  dyn_shifted;
  logic              stat_next_bit;
  logic              dyn_next_bit;
  logic              dyn_first_bit;

  assign xfer = SVALID & SREADY;

  // The shift direction follows the bit order so that the outgoing end of
  // the register always holds the next bit to send; vacated bits fill with 0.
  assign stat_shifted  = lsb_q ? (stat_sh >> 1) : (stat_sh << 1);
  assign dyn_shifted   = lsb_q ? (dyn_sh  >> 1) : (dyn_sh  << 1);

  // SDATA is registered, so the bit that follows the one being accepted is
  // taken one position in from the outgoing end of the current register.
  assign stat_next_bit = lsb_q ? stat_sh[1] : stat_sh[STAT_W-2];
  assign dyn_next_bit  = lsb_q ? dyn_sh[1]  : dyn_sh[DYN_W-2];
  assign dyn_first_bit = lsb_q ? dyn_sh[0]  : dyn_sh[DYN_W-1];

  // Accepting the final data bit of the frame.
  assign data_last = xfer &&
                     (((state == ST_SH_STAT) && (cnt == STAT_LAST) && (mode_q != MODE_BOTH)) ||
                      ((state == ST_SH_DYN)  && (cnt == DYN_LAST)));

  // NOTE: every register in this block uses non-blocking assignments so all
  // of them update together from the values present before the clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      SDATA     <= 1'b0;
      SVALID    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      cnt       <= '0;
      STATLATCH <= STAT_DEF;
      DYNLATCH  <= DYN_DEF;
      stat_sh   <= STAT_DEF;
      dyn_sh    <= DYN_DEF;
      lsb_q     <= 1'b0;
      mode_q    <= MODE_STAT;
`ifdef SHIFTREG_PARITY_EN
      par_acc   <= 1'b0;
`endif
    end else begin
      // NOTE: DONE and ERR default low every cycle so that any assertion below
      // lasts exactly one cycle without extra clearing logic.
      DONE <= 1'b0;
      ERR  <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (START) begin
            if (MODE == MODE_ILL) begin
              ERR <= 1'b1;
            end else begin
              STATLATCH <= STATREG;
              DYNLATCH  <= DYNREG;
              stat_sh   <= STATREG;
              dyn_sh    <= DYNREG;
              lsb_q     <= LSB_FIRST;
              mode_q    <= MODE;
              cnt       <= '0;
              SVALID    <= 1'b1;
              BUSY      <= 1'b1;
`ifdef SHIFTREG_PARITY_EN
              par_acc   <= 1'b0;
`endif
              // First bit comes straight from the source word so it is on
              // SDATA in the cycle after START.
              if (MODE == MODE_DYN) begin
                state <= ST_SH_DYN;
                SDATA <= LSB_FIRST ? DYNREG[0] : DYNREG[DYN_W-1];
              end else begin
                state <= ST_SH_STAT;
                SDATA <= LSB_FIRST ? STATREG[0] : STATREG[STAT_W-1];
              end
            end
          end
        end

        ST_SH_STAT: begin
          if (xfer) begin
`ifdef SHIFTREG_PARITY_EN
            par_acc <= par_acc ^ SDATA;
`endif
            stat_sh <= stat_shifted;
            if (cnt == STAT_LAST) begin
              cnt <= '0;
              if (mode_q == MODE_BOTH) begin
                // Word boundary without a bubble: SVALID stays high.
                state <= ST_SH_DYN;
                SDATA <= dyn_first_bit;
              end
            end else begin
              cnt   <= cnt + 1'b1;
              SDATA <= stat_next_bit;
            end
          end
        end

        ST_SH_DYN: begin
          if (xfer) begin
`ifdef SHIFTREG_PARITY_EN
            par_acc <= par_acc ^ SDATA;
`endif
            dyn_sh <= dyn_shifted;
            if (cnt == DYN_LAST) begin
              cnt <= '0;
            end else begin
              cnt   <= cnt + 1'b1;
              SDATA <= dyn_next_bit;
            end
          end
        end

`ifdef SHIFTREG_PARITY_EN
        ST_SH_PAR: begin
          if (xfer) begin
            state  <= ST_IDLE;
            SDATA  <= 1'b0;
            SVALID <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // End of the data portion of a frame. These assignments come after the
      // case so they take precedence over the per-state updates above.
      if (data_last) begin
`ifdef SHIFTREG_PARITY_EN
        // par_acc does not yet include the bit accepted on this edge.
        state <= ST_SH_PAR;
        SDATA <= par_acc ^ SDATA;
`else
        state  <= ST_IDLE;
        SDATA  <= 1'b0;
        SVALID <= 1'b0;
        BUSY   <= 1'b0;
        DONE   <= 1'b1;
`endif
      end
    end
  end

endmodule
